// File: rtl/id_regfile_sb_if.sv
// Decode-stage register file bundle: read ports, issue request, writeback and kill strobes.
// master drives requests and observes operands; slave is the register file.
interface id_regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 2
);
    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

    logic [NRD*AW-1:0]     rd_addr;
    logic [NRD-1:0]        rd_use;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_ready;
    logic                  issue_valid;
    logic                  issue_wr;
    logic [AW-1:0]         issue_dst;
    logic                  issue_ok;
    logic                  wb_en;
    logic [AW-1:0]         wb_addr;
    logic [DATA_W-1:0]     wb_data;
    logic                  kill_en;
    logic [AW-1:0]         kill_addr;
    logic                  sb_err;

    modport master (
        output rd_addr, rd_use, issue_valid, issue_wr, issue_dst,
        output wb_en, wb_addr, wb_data, kill_en, kill_addr,
        input  rd_data, rd_ready, issue_ok, sb_err
    );

    modport slave (
        input  rd_addr, rd_use, issue_valid, issue_wr, issue_dst,
        input  wb_en, wb_addr, wb_data, kill_en, kill_addr,
        output rd_data, rd_ready, issue_ok, sb_err
    );
endinterface

// File: rtl/id_regfile_sb.sv
// GPR array with write-through bypass and per-register pending-write scoreboard for ID.
// Latency: reads, ready and issue_ok are combinational; array, counters and sb_err update at the edge.
// Backpressure: issue_ok drops while a consumed source has an older producer or the dst counter is full.
module id_regfile_sb #(
    parameter int DATA_W  = 32,
    parameter int NREG    = 32,
    parameter int NRD     = 2,
    parameter int CNT_W   = 2,
    parameter int R0_ZERO = 1
) (
    input  logic           clk,
    input  logic           rst,
    id_regfile_sb_if.slave bus
);
    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [NREG-1:0][DATA_W-1:0] mem_q, mem_d;
    logic [NREG-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic                        sb_err_q, sb_err_d;

    logic [NRD*DATA_W-1:0] rd_data_c;
    logic [NRD-1:0]        rd_ready_c;
    logic                  dst_dec;
    logic                  dst_room;
    logic                  issue_ok_c;

    function automatic logic is_zero_reg(input logic [AW-1:0] a);
        return (R0_ZERO != 0) && (a == '0);
    endfunction

    // A source is final when no producer is pending, or the last one is writing through now.
    always_comb begin : read_path
        logic [AW-1:0] a;
        logic          hit;
        a          = '0;
        hit        = 1'b0;
        rd_data_c  = '0;
        rd_ready_c = '0;
        for (int i = 0; i < NRD; i++) begin
            a   = bus.rd_addr[i*AW +: AW];
            hit = bus.wb_en && (bus.wb_addr == a);
            if (is_zero_reg(a)) begin
                rd_data_c[i*DATA_W +: DATA_W] = '0;
                rd_ready_c[i]                 = 1'b1;
            end else begin
                rd_data_c[i*DATA_W +: DATA_W] = hit ? bus.wb_data : mem_q[a];
                rd_ready_c[i] = (cnt_q[a] == '0) || (hit && (cnt_q[a] == CNT_W'(1)));
            end
        end
    end

    always_comb begin : issue_path
        dst_dec    = (bus.wb_en && (bus.wb_addr == bus.issue_dst)) ||
                     (bus.kill_en && (bus.kill_addr == bus.issue_dst));
        dst_room   = !bus.issue_wr || is_zero_reg(bus.issue_dst) ||
                     (cnt_q[bus.issue_dst] != CNT_MAX) || dst_dec;
        issue_ok_c = bus.issue_valid && (&(rd_ready_c | ~bus.rd_use)) && dst_room;
    end

    // Saturating counters: any clamp means the producer bookkeeping went wrong, so latch sb_err.
    always_comb begin : next_state
        int nxt;
        nxt      = 0;
        mem_d    = mem_q;
        cnt_d    = cnt_q;
        sb_err_d = sb_err_q;
        if (bus.wb_en && !is_zero_reg(bus.wb_addr) && (int'(bus.wb_addr) < NREG)) begin
            mem_d[bus.wb_addr] = bus.wb_data;
        end
        for (int r = 0; r < NREG; r++) begin
            if (!((R0_ZERO != 0) && (r == 0))) begin
                nxt = int'(cnt_q[r])
                    + ((issue_ok_c && bus.issue_wr && (bus.issue_dst == AW'(r))) ? 1 : 0)
                    - ((bus.wb_en && (bus.wb_addr == AW'(r))) ? 1 : 0)
                    - ((bus.kill_en && (bus.kill_addr == AW'(r))) ? 1 : 0);
                if (nxt < 0) begin
                    nxt      = 0;
                    sb_err_d = 1'b1;
                end else if (nxt > int'(CNT_MAX)) begin
                    nxt      = int'(CNT_MAX);
                    sb_err_d = 1'b1;
                end
                cnt_d[r] = CNT_W'(nxt);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            cnt_q    <= '0;
            sb_err_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            cnt_q    <= cnt_d;
            sb_err_q <= sb_err_d;
        end
    end

    assign bus.rd_data  = rd_data_c;
    assign bus.rd_ready = rd_ready_c;
    assign bus.issue_ok = issue_ok_c;
    assign bus.sb_err   = sb_err_q;
endmodule

// File: tb/tb_id_regfile_sb.sv
// Bench for id_regfile_sb: directed scenarios plus randomized traffic against a register/counter model.
module tb_id_regfile_sb;
    localparam int DW   = 32;
    localparam int NR   = 32;
    localparam int NP   = 2;
    localparam int CMAX = 3;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    id_regfile_sb_if #(.DATA_W(DW), .NREG(NR), .NRD(NP)) bus();

    id_regfile_sb #(.DATA_W(DW), .NREG(NR), .NRD(NP), .CNT_W(2), .R0_ZERO(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference state: register contents, outstanding producers per register, sticky error.
    logic [31:0] m_mem [NR];
    int          m_cnt [NR];
    bit          m_err;
    logic [63:0] e_data;
    logic [1:0]  e_rdy;
    logic        e_ok;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_eval();
        logic [4:0]  a;
        logic        hit;
        logic        ok;
        for (int i = 0; i < NP; i++) begin
            a   = bus.rd_addr[i*5 +: 5];
            hit = bus.wb_en && (bus.wb_addr == a);
            if (a == 0) begin
                e_data[i*32 +: 32] = 32'h0;
                e_rdy[i]           = 1'b1;
            end else begin
                e_data[i*32 +: 32] = hit ? bus.wb_data : m_mem[a];
                e_rdy[i]           = (m_cnt[a] == 0) || (m_cnt[a] == 1 && hit);
            end
        end
        ok = bus.issue_valid;
        for (int i = 0; i < NP; i++) if (bus.rd_use[i] && !e_rdy[i]) ok = 1'b0;
        if (bus.issue_wr && bus.issue_dst != 0 && m_cnt[bus.issue_dst] >= CMAX &&
            !((bus.wb_en && bus.wb_addr == bus.issue_dst) ||
              (bus.kill_en && bus.kill_addr == bus.issue_dst))) ok = 1'b0;
        e_ok = ok;
    endfunction

    task automatic tick();
        int n;
        model_eval();
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < NR; r++) begin
                m_mem[r] = 32'h0;
                m_cnt[r] = 0;
            end
            m_err = 1'b0;
        end else begin
            if (bus.wb_en && bus.wb_addr != 0) m_mem[bus.wb_addr] = bus.wb_data;
            for (int r = 1; r < NR; r++) begin
                n = m_cnt[r];
                if (e_ok && bus.issue_wr && bus.issue_dst == 5'(r)) n++;
                if (bus.wb_en && bus.wb_addr == 5'(r)) n--;
                if (bus.kill_en && bus.kill_addr == 5'(r)) n--;
                if (n < 0) begin n = 0; m_err = 1'b1; end
                if (n > CMAX) begin n = CMAX; m_err = 1'b1; end
                m_cnt[r] = n;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        bus.rd_addr     = '0;
        bus.rd_use      = '0;
        bus.issue_valid = 1'b0;
        bus.issue_wr    = 1'b0;
        bus.issue_dst   = '0;
        bus.wb_en       = 1'b0;
        bus.wb_addr     = '0;
        bus.wb_data     = '0;
        bus.kill_en     = 1'b0;
        bus.kill_addr   = '0;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] use_v);
        bus.rd_addr = {a1, a0};
        bus.rd_use  = use_v;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        set_rd(5'd5, 5'd0, 2'b11);
        bus.issue_valid = 1'b1;
        #1;
        checks++; if (bus.rd_data !== 64'h0) begin errors++; $display("FAIL reset_rd_data: got %h want %h", bus.rd_data, 64'h0); end
        checks++; if (bus.rd_ready !== 2'b11) begin errors++; $display("FAIL reset_rd_ready: got %b want 11", bus.rd_ready); end
        checks++; if (bus.issue_ok !== 1'b1) begin errors++; $display("FAIL reset_issue_ok: got %b want 1", bus.issue_ok); end
        checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("FAIL reset_sb_err: got %b want 0", bus.sb_err); end
        tick();
    endtask

    task automatic test_bypass();
        idle();
        bus.issue_valid = 1'b1; bus.issue_wr = 1'b1; bus.issue_dst = 5'd8;
        #1;
        checks++; if (bus.issue_ok !== 1'b1) begin errors++; $display("FAIL byp_issue_dst8: got %b want 1", bus.issue_ok); end
        tick();
        idle();
        set_rd(5'd8, 5'd0, 2'b01);
        bus.issue_valid = 1'b1;
        #1;
        checks++; if (bus.rd_ready[0] !== 1'b0) begin errors++; $display("FAIL byp_pending_ready: got %b want 0", bus.rd_ready[0]); end
        checks++; if (bus.issue_ok !== 1'b0) begin errors++; $display("FAIL byp_pending_ok: got %b want 0", bus.issue_ok); end
        bus.wb_en = 1'b1; bus.wb_addr = 5'd8; bus.wb_data = 32'hDEADBEEF;
        #1;
        checks++; if (bus.rd_data[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL byp_wt_data: got %h want deadbeef", bus.rd_data[31:0]); end
        checks++; if (bus.rd_ready[0] !== 1'b1) begin errors++; $display("FAIL byp_wt_ready: got %b want 1", bus.rd_ready[0]); end
        checks++; if (bus.issue_ok !== 1'b1) begin errors++; $display("FAIL byp_wt_ok: got %b want 1", bus.issue_ok); end
        tick();
        idle();
        set_rd(5'd8, 5'd0, 2'b01);
        #1;
        checks++; if (bus.rd_data[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL byp_array_data: got %h want deadbeef", bus.rd_data[31:0]); end
        checks++; if (bus.rd_ready[0] !== 1'b1) begin errors++; $display("FAIL byp_array_ready: got %b want 1", bus.rd_ready[0]); end
        tick();
    endtask

    task automatic test_cnt_sat();
        idle();
        for (int k = 0; k < 3; k++) begin
            bus.issue_valid = 1'b1; bus.issue_wr = 1'b1; bus.issue_dst = 5'd4;
            #1;
            checks++; if (bus.issue_ok !== 1'b1) begin errors++; $display("FAIL sat_fill%0d: got %b want 1", k, bus.issue_ok); end
            tick();
        end
        #1;
        checks++; if (bus.issue_ok !== 1'b0) begin errors++; $display("FAIL sat_full: got %b want 0", bus.issue_ok); end
        bus.wb_en = 1'b1; bus.wb_addr = 5'd4; bus.wb_data = 32'h0000_0044;
        #1;
        checks++; if (bus.issue_ok !== 1'b1) begin errors++; $display("FAIL sat_full_wb: got %b want 1", bus.issue_ok); end
        tick();
        bus.wb_en = 1'b0;
        #1;
        checks++; if (bus.issue_ok !== 1'b0) begin errors++; $display("FAIL sat_still_full: got %b want 0", bus.issue_ok); end
        idle();
        for (int k = 0; k < 3; k++) begin
            bus.wb_en = 1'b1; bus.wb_addr = 5'd4; bus.wb_data = 32'h4400 + 32'(k);
            tick();
        end
        idle();
        set_rd(5'd0, 5'd4, 2'b10);
        #1;
        checks++; if (bus.rd_ready !== 2'b11) begin errors++; $display("FAIL sat_drained_ready: got %b want 11", bus.rd_ready); end
        checks++; if (bus.rd_data[63:32] !== 32'h4402) begin errors++; $display("FAIL sat_drained_data: got %h want 4402", bus.rd_data[63:32]); end
        checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("FAIL sat_sb_err: got %b want 0", bus.sb_err); end
        tick();
    endtask

    task automatic test_kill();
        idle();
        bus.issue_valid = 1'b1; bus.issue_wr = 1'b1; bus.issue_dst = 5'd9;
        tick();
        idle();
        set_rd(5'd9, 5'd0, 2'b01);
        bus.kill_en = 1'b1; bus.kill_addr = 5'd9;
        #1;
        checks++; if (bus.rd_ready[0] !== 1'b0) begin errors++; $display("FAIL kill_same_cycle_ready: got %b want 0", bus.rd_ready[0]); end
        tick();
        bus.kill_en = 1'b0;
        #1;
        checks++; if (bus.rd_ready[0] !== 1'b1) begin errors++; $display("FAIL kill_ready: got %b want 1", bus.rd_ready[0]); end
        checks++; if (bus.rd_data[31:0] !== 32'h0) begin errors++; $display("FAIL kill_data: got %h want 0", bus.rd_data[31:0]); end
        checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("FAIL kill_sb_err: got %b want 0", bus.sb_err); end
        tick();
    endtask

    task automatic test_r0_untracked();
        idle();
        set_rd(5'd0, 5'd0, 2'b11);
        bus.wb_en = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'h1234;
        #1;
        checks++; if (bus.rd_data !== 64'h0) begin errors++; $display("FAIL r0_wt: got %h want 0", bus.rd_data); end
        tick();
        idle();
        set_rd(5'd0, 5'd12, 2'b11);
        #1;
        checks++; if (bus.rd_data[31:0] !== 32'h0) begin errors++; $display("FAIL r0_array: got %h want 0", bus.rd_data[31:0]); end
        checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("FAIL r0_sb_err: got %b want 0", bus.sb_err); end
        bus.wb_en = 1'b1; bus.wb_addr = 5'd12; bus.wb_data = 32'hCAFE_0012;
        tick();
        bus.wb_en = 1'b0;
        #1;
        checks++; if (bus.sb_err !== 1'b1) begin errors++; $display("FAIL untracked_sb_err: got %b want 1", bus.sb_err); end
        checks++; if (bus.rd_data[63:32] !== 32'hCAFE_0012) begin errors++; $display("FAIL untracked_data: got %h want cafe0012", bus.rd_data[63:32]); end
        tick();
        tick();
        checks++; if (bus.sb_err !== 1'b1) begin errors++; $display("FAIL sticky_sb_err: got %b want 1", bus.sb_err); end
    endtask

    task automatic test_reset_mid();
        idle();
        bus.issue_valid = 1'b1; bus.issue_wr = 1'b1; bus.issue_dst = 5'd3;
        tick();
        rst = 1'b1;
        bus.wb_en = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h5555_AAAA;
        tick();
        rst = 1'b0;
        idle();
        set_rd(5'd3, 5'd12, 2'b11);
        bus.issue_valid = 1'b1; bus.issue_wr = 1'b1; bus.issue_dst = 5'd3;
        #1;
        checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("FAIL rstmid_sb_err: got %b want 0", bus.sb_err); end
        checks++; if (bus.rd_data !== 64'h0) begin errors++; $display("FAIL rstmid_data: got %h want 0", bus.rd_data); end
        checks++; if (bus.rd_ready !== 2'b11) begin errors++; $display("FAIL rstmid_ready: got %b want 11", bus.rd_ready); end
        checks++; if (bus.issue_ok !== 1'b1) begin errors++; $display("FAIL rstmid_ok: got %b want 1", bus.issue_ok); end
        tick();
    endtask

    task automatic test_random();
        idle();
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) < 2);
            set_rd(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
            bus.issue_valid = ($urandom_range(0, 99) < 70);
            bus.issue_wr    = ($urandom_range(0, 99) < 60);
            bus.issue_dst   = 5'($urandom_range(0, 7));
            bus.wb_en       = ($urandom_range(0, 99) < 40);
            bus.wb_addr     = 5'($urandom_range(0, 7));
            bus.wb_data     = $urandom;
            bus.kill_en     = ($urandom_range(0, 99) < 10);
            bus.kill_addr   = 5'($urandom_range(0, 7));
            #1;
            model_eval();
            checks++; if (bus.rd_data !== e_data) begin errors++; $display("FAIL rand_rd_data[%0d]: got %h want %h", n, bus.rd_data, e_data); end
            checks++; if (bus.rd_ready !== e_rdy) begin errors++; $display("FAIL rand_rd_ready[%0d]: got %b want %b", n, bus.rd_ready, e_rdy); end
            checks++; if (bus.issue_ok !== e_ok) begin errors++; $display("FAIL rand_issue_ok[%0d]: got %b want %b", n, bus.issue_ok, e_ok); end
            checks++; if (bus.sb_err !== m_err) begin errors++; $display("FAIL rand_sb_err[%0d]: got %b want %b", n, bus.sb_err, m_err); end
            tick();
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        m_err  = 1'b0;
        for (int r = 0; r < NR; r++) begin
            m_mem[r] = 32'h0;
            m_cnt[r] = 0;
        end
        idle();
        test_reset();
        test_bypass();
        test_cnt_sat();
        test_kill();
        test_r0_untracked();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
